decode_stage_wide: RTL and testbench

- Parametrised successor of the single-lane decode stage: decodes a bundle of LANES RV32I instructions per cycle into de_inst records.
- Adds a DEPTH-entry output queue with valid/ready handshakes on both sides, so upstream stalls are registered rather than combinational.
- Adds intra-bundle RAW dependency flags and flush.
- Sits between the fetch stage (if_id bundle) and the register-read stage (id_rd bundle).

---
 rtl/decode_stage_wide_pkg.sv | 64 ++++++
 rtl/decode_stage_wide_lane.sv | 102 ++++++++++
 rtl/decode_stage_wide.sv | 122 ++++++++++++
 tb/tb_decode_stage_wide.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_wide_pkg.sv
// Shared packages for the wide decode stage.
//   rv32i : opcode map and the funct3/funct7 values used by the legality check.
//   core  : pipeline records (if_id_t in, de_inst_t / id_rd_t out) and the
//           reset value of a decoded lane.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN adds de_inst_t.illegal.
// A bundle is LANES x id_rd_t; packages cannot take parameters, so the bundle
// typedef (id_rd_bundle_t) lives in the decode_stage_wide module.

package rv32i;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYS    = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_LD_RSV0 = 3'd3;
  localparam logic [2:0] F3_LD_RSV1 = 3'd6;
  localparam logic [2:0] F3_LD_RSV2 = 3'd7;
  localparam logic [2:0] F3_ST_MAX  = 3'd2;
  localparam logic [2:0] F3_BR_RSV0 = 3'd2;
  localparam logic [2:0] F3_BR_RSV1 = 3'd3;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
endpackage

package core;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        has_rs1;
    logic        has_rs2;
    logic        has_rd;
    logic [31:0] imm;
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic        illegal;
`endif
  } de_inst_t;

  typedef de_inst_t id_rd_t;

  localparam id_rd_t id_rd_rst = '0;
endpackage

// File: rtl/decode_stage_wide_lane.sv
// decode_lane: purely combinational RV32I decoder for one lane.
//   in_inst  : fetched pc/inst/valid (valid already gated by stage enable)
//   out_inst : decoded record; fields the opcode does not use are 0
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN (illegal flag + operand kill).

module decode_lane
  import core::*;
  import rv32i::*;
(
  input  if_id_t   in_inst,
  output de_inst_t out_inst
);
  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        use_rs1, use_rs2, use_rd, use_f3, use_f7;
  logic        kill;

  assign ins   = in_inst.inst;
  assign opc   = ins[6:0];
  assign f3    = ins[14:12];
  assign f7    = ins[31:25];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'h000};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic ill;

  always_comb begin
    ill = (ins[1:0] != 2'b11);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_FENCE, OPC_SYS: ;
      OPC_OP: begin
        if (f7 == F7_ALT) begin
          if (f3 != F3_ADD_SUB && f3 != F3_SRL_SRA) ill = 1'b1;
        end else if (f7 != F7_BASE) begin
          ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        // Shift-immediates reuse funct7 as the shift-type selector.
        if (f3 == F3_SLL || f3 == F3_SRL_SRA) begin
          if (f7 != F7_BASE && f7 != F7_ALT) ill = 1'b1;
          else if (f7 == F7_ALT && f3 == F3_SLL) ill = 1'b1;
        end
      end
      OPC_LOAD:   if (f3 == F3_LD_RSV0 || f3 == F3_LD_RSV1 || f3 == F3_LD_RSV2) ill = 1'b1;
      OPC_STORE:  if (f3 > F3_ST_MAX) ill = 1'b1;
      OPC_BRANCH: if (f3 == F3_BR_RSV0 || f3 == F3_BR_RSV1) ill = 1'b1;
      default:    ill = 1'b1;
    endcase
    ill = ill && in_inst.valid;
  end

  assign kill = !in_inst.valid || ill;
`else
  assign kill = !in_inst.valid;
`endif

  always_comb begin
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    use_f3   = 1'b0;
    use_f7   = 1'b0;
    out_inst = '0;
    out_inst.pc    = in_inst.pc;
    out_inst.inst  = ins;
    out_inst.valid = in_inst.valid;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin use_rd = 1'b1; out_inst.imm = imm_u; end
      OPC_JAL:            begin use_rd = 1'b1; out_inst.imm = imm_j; end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        use_rs1 = 1'b1; use_rd = 1'b1; out_inst.imm = imm_i;
      end
      OPC_BRANCH: begin use_f3 = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; out_inst.imm = imm_b; end
      OPC_STORE:  begin use_f3 = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; out_inst.imm = imm_s; end
      OPC_OP: begin
        use_f3 = 1'b1; use_f7 = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
      end
      OPC_SYS: begin use_f3 = 1'b1; use_f7 = 1'b1; end
      default: ;
    endcase
    out_inst.funct3  = use_f3  ? f3         : 3'd0;
    out_inst.funct7  = use_f7  ? f7         : 7'd0;
    out_inst.rs1     = use_rs1 ? ins[19:15] : 5'd0;
    out_inst.rs2     = use_rs2 ? ins[24:20] : 5'd0;
    out_inst.rd      = use_rd  ? ins[11:7]  : 5'd0;
    out_inst.has_rs1 = use_rs1 && !kill;
    out_inst.has_rs2 = use_rs2 && !kill;
    // Writes to x0 are architecturally dropped, so they create no hazard.
    out_inst.has_rd  = use_rd && !kill && (ins[11:7] != 5'd0);
`ifdef DECODE_ILLEGAL_CHECK_EN
    out_inst.illegal = ill;
`endif
  end
endmodule

// File: rtl/decode_stage_wide.sv
// decode_stage_wide: decodes LANES RV32I instructions per cycle and queues the
// decoded bundles (with intra-bundle RAW flags) in a DEPTH-entry FIFO.
//   clk, rst_n (async, active-low), en (gates enqueue), flush (empties queue)
//   in_valid/in_ready/in_bundle    : fetch-side handshake, LANES x if_id_t
//   out_valid/out_ready/out_bundle : register-read side, LANES x id_rd_t
//   out_dep   : bit [j*LANES+i] set when lane j reads rd of earlier lane i
//   occupancy : number of queued bundles
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN (per-lane illegal flag).

module decode_stage_wide
  import core::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  if_id_t [LANES-1:0]        in_bundle,
  output logic                      out_valid,
  input  logic                      out_ready,
  output id_rd_t [LANES-1:0]        out_bundle,
  output logic [LANES*LANES-1:0]    out_dep,
  output logic [$clog2(DEPTH):0]    occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef id_rd_t [LANES-1:0] id_rd_bundle_t;
  typedef logic [LANES*LANES-1:0] dep_t;

  if_id_t [LANES-1:0] lane_in;
  id_rd_t             dec [LANES];
  id_rd_bundle_t      dec_bundle;
  dep_t               dep_c;

  id_rd_bundle_t mem_q [DEPTH];
  id_rd_bundle_t mem_d [DEPTH];
  dep_t          dep_q [DEPTH];
  dep_t          dep_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq, deq;

  always_comb begin
    lane_in = in_bundle;
    for (int k = 0; k < LANES; k++) lane_in[k].valid = in_bundle[k].valid && en;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    decode_lane u_dec (
      .in_inst  (lane_in[g]),
      .out_inst (dec[g])
    );
  end

  always_comb begin
    dec_bundle = '0;
    dep_c      = '0;
    for (int j = 0; j < LANES; j++) begin
      dec_bundle[j] = dec[j];
      for (int i = 0; i < j; i++) begin
        dep_c[j*LANES+i] = dec[i].valid && dec[i].has_rd && dec[j].valid &&
                           ((dec[j].has_rs1 && dec[j].rs1 == dec[i].rd) ||
                            (dec[j].has_rs2 && dec[j].rs2 == dec[i].rd));
      end
    end
  end

  // in_ready depends only on the registered count and flush, never on out_ready.
  assign in_ready   = (count_q < DEPTH_C) && !flush;
  assign out_valid  = (count_q != '0);
  assign enq        = in_valid && in_ready && en;
  assign deq        = out_valid && out_ready;
  assign out_bundle = mem_q[rd_q];
  assign out_dep    = dep_q[rd_q];
  assign occupancy  = count_q;

  always_comb begin
    mem_d   = mem_q;
    dep_d   = dep_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        mem_d[wr_q] = dec_bundle;
        dep_d[wr_q] = dep_c;
        wr_d        = wr_q + 1'b1;
      end
      if (deq) rd_d = rd_q + 1'b1;
      if (enq && !deq)      count_d = count_q + 1'b1;
      else if (!enq && deq) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= {LANES{id_rd_rst}};
        dep_q[e] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      dep_q   <= dep_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_decode_stage_wide.sv
module tb_decode_stage_wide;
  import core::*;

  localparam int LANES = 2;
  localparam int DEPTH = 2;

  logic                   clk = 1'b0;
  logic                   rst_n, en, flush, in_valid, in_ready, out_valid, out_ready;
  if_id_t [LANES-1:0]     in_bundle;
  id_rd_t [LANES-1:0]     out_bundle;
  logic [LANES*LANES-1:0] out_dep;
  logic [$clog2(DEPTH):0] occupancy;

  int tests  = 0;
  int failed = 0;

  decode_stage_wide #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_bundle(in_bundle),
    .out_valid(out_valid), .out_ready(out_ready), .out_bundle(out_bundle),
    .out_dep(out_dep), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hrd;
    logic        hs1;
    logic        hs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } lane_exp_t;

  typedef struct {
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic        v0;
    logic        v1;
    lane_exp_t   e0;
    lane_exp_t   e1;
    logic [3:0]  dep;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic lane_exp_t act_lane(input int k);
    lane_exp_t a;
    a.rd  = out_bundle[k].rd;
    a.rs1 = out_bundle[k].rs1;
    a.rs2 = out_bundle[k].rs2;
    a.hrd = out_bundle[k].has_rd;
    a.hs1 = out_bundle[k].has_rs1;
    a.hs2 = out_bundle[k].has_rs2;
    a.f3  = out_bundle[k].funct3;
    a.f7  = out_bundle[k].funct7;
    a.imm = out_bundle[k].imm;
    return a;
  endfunction

  task automatic drive(input logic [31:0] i0, input logic [31:0] i1,
                       input logic v0, input logic v1, input logic [31:0] pc0);
    in_bundle[0].pc    = pc0;
    in_bundle[0].inst  = i0;
    in_bundle[0].valid = v0;
    in_bundle[1].pc    = pc0 + 32'd4;
    in_bundle[1].inst  = i1;
    in_bundle[1].valid = v1;
  endtask

  initial begin
    // addi x5,x0,1 / add x6,x5,x5 : lane1 depends on lane0
    vecs[0] = '{32'h00100293, 32'h00528333, 1'b1, 1'b1,
                '{5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 3'd0, 7'h00, 32'h00000001},
                '{5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 3'd0, 7'h00, 32'h00000000},
                4'b0100};
    // lui x1 / beq x1,x2,-4 : beq reads x1 written by lui, so bit[2] is set
    vecs[1] = '{32'h123450B7, 32'hFE208EE3, 1'b1, 1'b1,
                '{5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 7'h00, 32'h12345000},
                '{5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 3'd0, 7'h00, 32'hFFFFFFFC},
                4'b0100};
    // sw x5,8(x2) / jal x1,-8 : no lane0 rd, no dependency
    vecs[2] = '{32'h00512423, 32'hFF9FF0EF, 1'b1, 1'b1,
                '{5'd0, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 3'd2, 7'h00, 32'h00000008},
                '{5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 7'h00, 32'hFFFFFFF8},
                4'b0000};
    // nop (rd=x0 -> has_rd=0) / sra x7,x3,x4
    vecs[3] = '{32'h00000013, 32'h4041D3B3, 1'b1, 1'b1,
                '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 7'h00, 32'h00000000},
                '{5'd7, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 3'd5, 7'h20, 32'h00000000},
                4'b0000};
    // lw x8,-4(x9) / add x10,x8,x8 with lane1 invalid -> no has_* and no dep
    vecs[4] = '{32'hFFC4A403, 32'h00840533, 1'b1, 1'b0,
                '{5'd8, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 3'd0, 7'h00, 32'hFFFFFFFC},
                '{5'd10, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 3'd0, 7'h00, 32'h00000000},
                4'b0000};
    // mret (sys: funct3/funct7 only) / fence (no operands)
    vecs[5] = '{32'h30200073, 32'h0FF0000F, 1'b1, 1'b1,
                '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 7'h18, 32'h00000000},
                '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 7'h00, 32'h00000000},
                4'b0000};

    rst_n = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_dep", out_dep, 0);
    chk("rst_bundle_zero", out_bundle == '0, 1);
    @(negedge clk); rst_n = 1'b1;

    // table-driven decode checks, one bundle in flight at a time
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      drive(vecs[n].inst0, vecs[n].inst1, vecs[n].v0, vecs[n].v1, 32'h1000 + 32'(n) * 32'h10);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_out_valid", n), out_valid, 1);
      chk($sformatf("vec%0d_lane0", n), act_lane(0), vecs[n].e0);
      chk($sformatf("vec%0d_lane1", n), act_lane(1), vecs[n].e1);
      chk($sformatf("vec%0d_dep", n), out_dep, vecs[n].dep);
      chk($sformatf("vec%0d_lane_valid", n), {out_bundle[1].valid, out_bundle[0].valid},
          {vecs[n].v1, vecs[n].v0});
      chk($sformatf("vec%0d_pc1", n), out_bundle[1].pc, 32'h1004 + 32'(n) * 32'h10);
    end
    @(negedge clk);
    chk("table_drained", occupancy, 0);

    // all-zero word: not a valid opcode; no operands either way
    drive(32'h00000000, 32'h00000013, 1'b1, 1'b1, 32'h2000);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("zero_inst_lane0", act_lane(0), 60'h0);
`ifdef DECODE_ILLEGAL_CHECK_EN
    chk("zero_inst_illegal0", out_bundle[0].illegal, 1);
    chk("zero_inst_illegal1", out_bundle[1].illegal, 0);
`endif
    @(negedge clk);

    // en=0 blocks enqueue
    en = 1'b0; in_valid = 1'b1;
    drive(vecs[0].inst0, vecs[0].inst1, 1'b1, 1'b1, 32'h2100);
    @(negedge clk);
    chk("en_low_occupancy", occupancy, 0);
    chk("en_low_out_valid", out_valid, 0);
    en = 1'b1; in_valid = 1'b0;

    // backpressure: third bundle held upstream, in-order drain with wrap
    out_ready = 1'b0;
    @(negedge clk);
    drive(vecs[0].inst0, vecs[0].inst1, 1'b1, 1'b1, 32'h100); in_valid = 1'b1;
    @(negedge clk);
    chk("bp_occ1", occupancy, 1);
    chk("bp_ready1", in_ready, 1);
    drive(vecs[1].inst0, vecs[1].inst1, 1'b1, 1'b1, 32'h200);
    @(negedge clk);
    chk("bp_occ2", occupancy, 2);
    chk("bp_ready_full", in_ready, 0);
    drive(vecs[2].inst0, vecs[2].inst1, 1'b1, 1'b1, 32'h300);
    @(negedge clk);
    chk("bp_occ_held", occupancy, 2);
    chk("bp_head_first", out_bundle[0].pc, 32'h100);
    chk("bp_head_first_dep", out_dep, 4'b0100);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_after_deq", in_ready, 1);
    chk("bp_occ_after_deq", occupancy, 1);
    chk("bp_head_second", out_bundle[0].pc, 32'h200);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_occ_enq_deq", occupancy, 1);
    chk("bp_head_third", out_bundle[0].pc, 32'h300);
    chk("bp_head_third_imm", out_bundle[1].imm, 32'hFFFFFFF8);
    @(negedge clk);
    chk("bp_drained", occupancy, 0);
    chk("bp_drained_valid", out_valid, 0);

    // flush with full queue and a same-cycle enqueue attempt
    out_ready = 1'b0;
    drive(vecs[3].inst0, vecs[3].inst1, 1'b1, 1'b1, 32'h400); in_valid = 1'b1;
    @(negedge clk);
    drive(vecs[3].inst0, vecs[3].inst1, 1'b1, 1'b1, 32'h500);
    @(negedge clk);
    chk("fl_full", occupancy, 2);
    flush = 1'b1; out_ready = 1'b1;
    drive(vecs[0].inst0, vecs[0].inst1, 1'b1, 1'b1, 32'h700);
    #1;
    chk("fl_in_ready_low", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_occupancy", occupancy, 0);
    chk("fl_out_valid", out_valid, 0);
    @(negedge clk);
    chk("fl_never_output", out_valid, 0);

    // asynchronous reset with two bundles queued
    out_ready = 1'b0;
    drive(vecs[0].inst0, vecs[0].inst1, 1'b1, 1'b1, 32'h800); in_valid = 1'b1;
    @(negedge clk);
    drive(vecs[1].inst0, vecs[1].inst1, 1'b1, 1'b1, 32'h900);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_full", occupancy, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_occupancy", occupancy, 0);
    chk("ar_out_dep", out_dep, 0);
    chk("ar_bundle_zero", out_bundle == '0, 1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    drive(vecs[0].inst0, vecs[0].inst1, 1'b1, 1'b1, 32'hA00); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_resume_valid", out_valid, 1);
    chk("ar_resume_lane0", act_lane(0), vecs[0].e0);
    chk("ar_resume_dep", out_dep, 4'b0100);
    @(negedge clk);
    chk("ar_resume_drained", occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
